// File: rtl/perceptron_infer.sv
// Byte-serial perceptron inference engine: weight load, sequential signed MAC, step activation.
// Optional bias register enabled by defining PERCEPTRON_BIAS_EN.
module perceptron_infer #(
   parameter int N_DIM = 2,
   parameter int DW    = 8,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_cmd,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_class,
   output logic             busy,
   output logic             err
);

   localparam int IDX_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;

   localparam logic [1:0] CMD_WRITE_W = 2'b00;
   localparam logic [1:0] CMD_FEATURE = 2'b01;
   localparam logic [1:0] CMD_CLEAR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_OUT   = 2'b10
   } state_t;

   state_t             state_r,     state_nxt_s;
   logic [DW-1:0]      w_r [N_DIM];
   logic [DW-1:0]      w_nxt_s [N_DIM];
   logic [IDX_W-1:0]   w_idx_r,     w_idx_nxt_s;
   logic [IDX_W-1:0]   feat_idx_r,  feat_idx_nxt_s;
   logic [ACC_W-1:0]   acc_r,       acc_nxt_s;
   logic               out_valid_r, out_valid_nxt_s;
   logic [ACC_W-1:0]   out_acc_r,   out_acc_nxt_s;
   logic               out_class_r, out_class_nxt_s;
   logic               err_r,       err_nxt_s;

   logic               accept_s;
   logic               last_feat_s;
   logic [2*DW-1:0]    feat_ext_s;
   logic [2*DW-1:0]    w_ext_s;
   logic [2*DW-1:0]    prod_s;
   logic [ACC_W-1:0]   prod_ext_s;
   logic [ACC_W-1:0]   init_s;
   logic [ACC_W-1:0]   sum_s;

`ifdef PERCEPTRON_BIAS_EN
   logic [DW-1:0]      bias_r, bias_nxt_s;
`endif

   assign in_ready  = ~out_valid_r;
   assign out_valid = out_valid_r;
   assign out_acc   = out_acc_r;
   assign out_class = out_class_r;
   assign err       = err_r;
   assign busy      = (feat_idx_r != {IDX_W{1'b0}});

   // Signed product at full 2*DW width, then sign-extended into the accumulator width.
   always_comb begin
      feat_ext_s  = {{DW{in_data[DW-1]}}, in_data};
      w_ext_s     = {{DW{w_r[feat_idx_r][DW-1]}}, w_r[feat_idx_r]};
      prod_s      = feat_ext_s * w_ext_s;
      prod_ext_s  = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
`ifdef PERCEPTRON_BIAS_EN
      init_s      = {{(ACC_W-DW){bias_r[DW-1]}}, bias_r};
`else
      init_s      = {ACC_W{1'b0}};
`endif
      if (feat_idx_r == {IDX_W{1'b0}}) begin
         sum_s = init_s + prod_ext_s;
      end else begin
         sum_s = acc_r + prod_ext_s;
      end
      accept_s    = in_valid & ~out_valid_r;
      last_feat_s = (feat_idx_r == IDX_W'(N_DIM-1));
   end

   // Next-state and datapath update for the command FSM.
   always_comb begin
      state_nxt_s     = state_r;
      w_nxt_s         = w_r;
      w_idx_nxt_s     = w_idx_r;
      feat_idx_nxt_s  = feat_idx_r;
      acc_nxt_s       = acc_r;
      out_valid_nxt_s = out_valid_r;
      out_acc_nxt_s   = out_acc_r;
      out_class_nxt_s = out_class_r;
      err_nxt_s       = 1'b0;
`ifdef PERCEPTRON_BIAS_EN
      bias_nxt_s      = bias_r;
`endif
      case (state_r)
         ST_IDLE, ST_ACCUM: begin
            if (accept_s) begin
               case (in_cmd)
                  CMD_WRITE_W: begin
                     if (state_r == ST_IDLE) begin
                        w_nxt_s[w_idx_r] = in_data;
                        if (w_idx_r == IDX_W'(N_DIM-1)) begin
                           w_idx_nxt_s = {IDX_W{1'b0}};
                        end else begin
                           w_idx_nxt_s = w_idx_r + IDX_W'(1);
                        end
                     end else begin
                        err_nxt_s = 1'b1;
                     end
                  end
                  CMD_FEATURE: begin
                     acc_nxt_s = sum_s;
                     if (last_feat_s) begin
                        feat_idx_nxt_s  = {IDX_W{1'b0}};
                        out_acc_nxt_s   = sum_s;
                        out_class_nxt_s = ~sum_s[ACC_W-1] & (sum_s != {ACC_W{1'b0}});
                        out_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_OUT;
                     end else begin
                        feat_idx_nxt_s  = feat_idx_r + IDX_W'(1);
                        state_nxt_s     = ST_ACCUM;
                     end
                  end
                  CMD_CLEAR: begin
                     feat_idx_nxt_s = {IDX_W{1'b0}};
                     w_idx_nxt_s    = {IDX_W{1'b0}};
                     acc_nxt_s      = {ACC_W{1'b0}};
                     state_nxt_s    = ST_IDLE;
                  end
                  default: begin
`ifdef PERCEPTRON_BIAS_EN
                     if (state_r == ST_IDLE) begin
                        bias_nxt_s = in_data;
                     end else begin
                        err_nxt_s = 1'b1;
                     end
`else
                     err_nxt_s = 1'b1;
`endif
                  end
               endcase
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_nxt_s = 1'b0;
               state_nxt_s     = ST_IDLE;
            end else begin
               out_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            feat_idx_nxt_s  = {IDX_W{1'b0}};
            out_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         for (int i = 0; i < N_DIM; i++) begin
            w_r[i] <= {DW{1'b0}};
         end
         w_idx_r     <= {IDX_W{1'b0}};
         feat_idx_r  <= {IDX_W{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         out_valid_r <= 1'b0;
         out_acc_r   <= {ACC_W{1'b0}};
         out_class_r <= 1'b0;
         err_r       <= 1'b0;
`ifdef PERCEPTRON_BIAS_EN
         bias_r      <= {DW{1'b0}};
`endif
      end else begin
         state_r     <= state_nxt_s;
         for (int i = 0; i < N_DIM; i++) begin
            w_r[i] <= w_nxt_s[i];
         end
         w_idx_r     <= w_idx_nxt_s;
         feat_idx_r  <= feat_idx_nxt_s;
         acc_r       <= acc_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_acc_r   <= out_acc_nxt_s;
         out_class_r <= out_class_nxt_s;
         err_r       <= err_nxt_s;
`ifdef PERCEPTRON_BIAS_EN
         bias_r      <= bias_nxt_s;
`endif
      end
   end

endmodule

// File: doc/perceptron_infer.md
Name: perceptron_infer

Overview:
Inference-side counterpart to the perceptron trainer. It holds a weight vector written over a byte-serial command stream, then accepts feature vectors over the same stream. For each vector it computes the signed dot product sequentially, one MAC per accepted byte, and returns the accumulator plus a step-activation class bit through a valid/ready output stage. It sits between the 8-bit pad interface (ui_in/uo_out) and downstream logic that consumes classification results.

Parameters:
N_DIM, 2, features per vector (1..8); also the number of weight registers
DW, 8, weight/feature width; two's-complement signed
ACC_W, 20, accumulator width; must be >= 2*DW + clog2(N_DIM) + 1, so overflow is impossible

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid && in_ready
in_cmd  in  2  00=WRITE_W, 01=FEATURE, 10=CLEAR, 11=reserved/BIAS
in_data  in  DW  signed payload
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  signed dot product
out_class  out  1  1 iff out_acc > 0 (strict)
busy  out  1  1 while feat_idx != 0 (feature vector partially received)
err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (rst_n=0 at posedge): all W[i]=0, bias=0, w_idx=0, feat_idx=0, acc=0, out_valid=0, out_acc=0, out_class=0, err=0. Reset mid-vector discards the partial vector and any pending result.
- in_ready = !out_valid. No input is accepted while a result is pending.
- FSM states:
  - IDLE: feat_idx==0, out_valid==0.
  - ACCUM: 0 < feat_idx < N_DIM.
  - OUT: out_valid==1.
- WRITE_W, accepted in IDLE: W[w_idx] <= in_data. w_idx increments and wraps from N_DIM-1 to 0.
- WRITE_W in ACCUM: byte consumed, err=1 next cycle, W and w_idx unchanged.
- FEATURE:
  - Product = sext(in_data)*sext(W[feat_idx]), computed full-width and sign-extended to ACC_W.
  - If feat_idx==0: acc <= init + product, where init = bias (sign-extended) if PERCEPTRON_BIAS_EN is defined, else 0. Otherwise acc <= acc + product.
  - feat_idx increments.
  - On the N_DIM-th feature: feat_idx <= 0, out_acc <= final sum, out_class <= (final sum > 0), out_valid <= 1 on the next edge. Latency is 1 cycle from the last accepted feature to out_valid.
- OUT: out_acc and out_class stay stable until out_valid && out_ready, which clears out_valid at that edge. in_ready rises the following cycle.
- CLEAR: feat_idx <= 0, w_idx <= 0, acc <= 0. Weights and bias are retained. Legal in IDLE and ACCUM, and never errors.
- Code 11 without the macro: byte consumed, err pulse, no state change.
- err is registered: high exactly one cycle after the offending transfer, otherwise 0.
- Back-to-back transfers at one byte per cycle are sustained until OUT.

Optional Feature:
PERCEPTRON_BIAS_EN
- Defined: code 11 writes the bias register (signed DW). It is legal in IDLE; in ACCUM it raises err and the bias is unchanged. Each vector's accumulation starts from sext(bias).
- Undefined: no bias register; code 11 is illegal (err pulse); accumulation starts from 0.

Test Plan:
- Reset, then WRITE_W 4, 9; FEATURE 2, 3 -> out_valid 1 cycle after the second feature, out_acc=35, out_class=1, busy=0.
- WRITE_W 0xFB(-5), 3; FEATURE 2, 3 -> out_acc=-1 (all ones), out_class=0. Then WRITE_W 3, 0xFE(-2); FEATURE 2, 3 -> out_acc=0, out_class=0 (strict compare).
- Result pending, out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out_acc stable, no features consumed. Raise out_ready -> out_valid drops at that edge, next vector accepted the cycle after.
- FEATURE 2, then WRITE_W 7 -> err pulses 1 cycle, weights unchanged. FEATURE 3 completes the vector with the original weights (acc=35). CLEAR mid-vector -> busy=0, next vector restarts at index 0.
- rst_n=0 for one edge after one feature -> all outputs 0, weights 0. A full vector 5, 5 then yields out_acc=0, out_class=0.
- With PERCEPTRON_BIAS_EN: BIAS 0xF6(-10), weights 4, 9, features 2, 3 -> out_acc=25. Without the macro: code 11 -> err pulse, and the same vector yields 35.
